// File: rtl/fm_demod_pkg.sv
// Shared types and constants for the FM demodulator: FSM states, the CORDIC
// arctangent table (16-bit phase, 2^16 counts = 2*pi) and a clog2 helper.
package fm_demod_pkg;

    typedef enum logic [1:0] {IDLE, PRE, ROT, DIFF} state_t;

    localparam int ATAN_ENTRIES = 14;

    // atan(2^-i) scaled to 2^16 counts per turn, rounded to nearest.
    function automatic logic [15:0] atan_lut(input int idx);
        case (idx)
            0:       return 16'd8192;
            1:       return 16'd4836;
            2:       return 16'd2555;
            3:       return 16'd1297;
            4:       return 16'd651;
            5:       return 16'd326;
            6:       return 16'd163;
            7:       return 16'd81;
            8:       return 16'd41;
            9:       return 16'd20;
            10:      return 16'd10;
            11:      return 16'd5;
            12:      return 16'd3;
            13:      return 16'd1;
            default: return 16'd0;
        endcase
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/fm_demodulator_if.sv
// Sample-stream bundle between the I/Q source and the demodulator.
interface fm_demodulator_if #(
    parameter int WIDTH = 16
);
    logic signed [WIDTH-1:0] data_in_i;
    logic signed [WIDTH-1:0] data_in_q;
    logic                    stb_in;
    logic signed [WIDTH-1:0] data_out;
    logic                    stb_out;
    logic                    overrun;

    modport master (
        output data_in_i, data_in_q, stb_in,
        input  data_out, stb_out, overrun
    );

    modport slave (
        input  data_in_i, data_in_q, stb_in,
        output data_out, stb_out, overrun
    );
endinterface

// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring CORDIC: one quadrant pre-rotation cycle followed by ITER
// micro-rotations, leaving the vector angle in o_z.
module cordic_vectoring_iter
    import fm_demod_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ZWIDTH = 16,
    parameter int ITER   = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic signed [WIDTH-1:0] i_x,
    input  logic signed [WIDTH-1:0] i_y,
    output logic                    o_done,
    output logic [ZWIDTH-1:0]       o_z
);
    // Two guard bits: negating the most-negative input plus the 1.647 gain.
    localparam int XW = WIDTH + 2;
    localparam int IW = clog2(ITER + 1);

    state_t                r_phase;
    logic signed [XW-1:0]  r_x;
    logic signed [XW-1:0]  r_y;
    logic [ZWIDTH-1:0]     r_z;
    logic [IW-1:0]         r_iter;
    logic signed [XW-1:0]  w_xs;
    logic signed [XW-1:0]  w_ys;
    logic [ZWIDTH-1:0]     w_atan;

    assign w_xs   = r_x >>> r_iter;
    assign w_ys   = r_y >>> r_iter;
    assign w_atan = ZWIDTH'(atan_lut(int'(r_iter)));
    assign o_done = (r_phase == ROT) && (r_iter == IW'(ITER - 1));
    assign o_z    = r_z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_iter  <= '0;
        end else if (i_start) begin
            r_phase <= PRE;
            r_x     <= XW'(i_x);
            r_y     <= XW'(i_y);
        end else begin
            case (r_phase)
                PRE: begin
                    if (r_x[XW-1]) begin
                        r_x <= -r_x;
                        r_y <= -r_y;
                        r_z <= {1'b1, {(ZWIDTH-1){1'b0}}};
                    end else begin
                        r_z <= '0;
                    end
                    r_iter  <= '0;
                    r_phase <= ROT;
                end
                ROT: begin
                    // NOTE: non-blocking updates read the pre-edge r_x/r_y, so each
                    // cross-coupled step uses the old pair on both sides.
                    if (!r_y[XW-1]) begin
                        r_x <= r_x + w_ys;
                        r_y <= r_y - w_xs;
                        r_z <= r_z + w_atan;
                    end else begin
                        r_x <= r_x - w_ys;
                        r_y <= r_y + w_xs;
                        r_z <= r_z - w_atan;
                    end
                    r_iter <= r_iter + 1'b1;
                    if (o_done) r_phase <= IDLE;
                end
                default: r_phase <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fm_demodulator.sv
// FM demodulator top: CORDIC phase extraction, phase differentiator and an
// accumulate-and-dump decimator with saturating output and sticky overrun flag.
module fm_demodulator
    import fm_demod_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ZWIDTH = 16,
    parameter int ITER   = 14,
    parameter int DECIM  = 100,
    parameter int OSHIFT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    fm_demodulator_if.slave bus
);
    localparam int AW = ZWIDTH + clog2(DECIM);
    localparam int CW = clog2(DECIM + 1);
    localparam logic signed [AW-1:0] SAT_HI = AW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_LO = AW'(-(2 ** (WIDTH - 1)));

    state_t                   r_state;
    logic [ZWIDTH-1:0]        r_phi_prev;
    logic                     r_primed;
    logic signed [AW-1:0]     r_acc;
    logic [CW-1:0]            r_count;
    logic signed [WIDTH-1:0]  r_data_out;
    logic                     r_stb_out;
    logic                     r_overrun;

    logic                     w_accept;
    logic                     w_done;
    logic [ZWIDTH-1:0]        w_z;
    logic signed [ZWIDTH-1:0] w_dphi;
    logic                     w_dump;
    logic signed [AW-1:0]     w_acc_base;
    logic [CW-1:0]            w_cnt_base;
    logic signed [AW-1:0]     w_shifted;
    logic signed [WIDTH-1:0]  w_sat;

    assign w_accept   = bus.stb_in && (r_state == IDLE);
    // Modular subtraction makes a step across +/-pi come out as a small signed value.
    assign w_dphi     = w_z - r_phi_prev;
    assign w_dump     = (r_count == CW'(DECIM));
    assign w_acc_base = w_dump ? '0 : r_acc;
    assign w_cnt_base = w_dump ? '0 : r_count;
    assign w_shifted  = r_acc >>> OSHIFT;

    always_comb begin
        // NOTE: the unconditional default keeps w_sat from inferring a latch.
        w_sat = WIDTH'(w_shifted);
        if (w_shifted > SAT_HI)      w_sat = WIDTH'(SAT_HI);
        else if (w_shifted < SAT_LO) w_sat = WIDTH'(SAT_LO);
    end

    cordic_vectoring_iter #(
        .WIDTH  (WIDTH),
        .ZWIDTH (ZWIDTH),
        .ITER   (ITER)
    ) u_cordic (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_accept),
        .i_x     (bus.data_in_i),
        .i_y     (bus.data_in_q),
        .o_done  (w_done),
        .o_z     (w_z)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_phi_prev <= '0;
            r_primed   <= 1'b0;
            r_acc      <= '0;
            r_count    <= '0;
            r_data_out <= '0;
            r_stb_out  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            case (r_state)
                IDLE:    if (bus.stb_in) r_state <= PRE;
                PRE:     r_state <= ROT;
                ROT:     if (w_done) r_state <= DIFF;
                default: r_state <= IDLE;
            endcase

            if (bus.stb_in && (r_state != IDLE)) r_overrun <= 1'b1;

            r_stb_out <= w_dump;
            if (w_dump) r_data_out <= w_sat;

            // A DIFF landing in the dump cycle adds into the freshly cleared sum.
            if ((r_state == DIFF) && r_primed) begin
                r_acc   <= w_acc_base + AW'(w_dphi);
                r_count <= w_cnt_base + 1'b1;
            end else if (w_dump) begin
                r_acc   <= '0;
                r_count <= '0;
            end

            if (r_state == DIFF) begin
                r_phi_prev <= w_z;
                r_primed   <= 1'b1;
            end
        end
    end

    assign bus.data_out = r_data_out;
    assign bus.stb_out  = r_stb_out;
    assign bus.overrun  = r_overrun;

endmodule

// File: tb/tb_fm_demodulator.sv
// Directed bench for fm_demodulator: real-valued atan2 phase model drives an
// expected-output queue; one negedge process checks every output cycle.
module tb_fm_demodulator;
    localparam int  WIDTH   = 16;
    localparam int  DECIM   = 100;
    localparam int  OSHIFT  = 4;
    localparam int  SPACING = 20;
    localparam int  TOL     = 8;
    localparam real PI      = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fm_demodulator_if #(.WIDTH(WIDTH)) bus ();

    fm_demodulator #(
        .WIDTH(WIDTH), .ZWIDTH(16), .ITER(14), .DECIM(DECIM), .OSHIFT(OSHIFT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int  total = 0;
    int  bad   = 0;
    int  exp_q[$];
    bit  m_primed;
    real m_prev;
    real m_acc;
    int  m_cnt;
    bit  m_overrun;
    int  last_exp;
    int  last_got;

    task automatic check(input string name, input bit ok, input int got, input int want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int round_r(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
    endfunction

    function automatic int sat_out(input real v);
        if (v > 32767.0)  return 32767;
        if (v < -32768.0) return -32768;
        return $rtoi(v);
    endfunction

    // Ideal phase in counts of 2^16 per turn; the origin is taken as phase 0.
    function automatic real phase_counts(input int si, input int sq);
        if (si == 0 && sq == 0) return 0.0;
        return $atan2(real'(sq), real'(si)) * 65536.0 / (2.0 * PI);
    endfunction

    task automatic model_feed(input int si, input int sq);
        real p;
        real d;
        p = phase_counts(si, sq);
        if (m_primed) begin
            d = p - m_prev;
            while (d >= 32768.0) d -= 65536.0;
            while (d < -32768.0) d += 65536.0;
            m_acc += d;
            m_cnt++;
            if (m_cnt == DECIM) begin
                exp_q.push_back(sat_out($floor(m_acc / real'(1 << OSHIFT))));
                m_acc = 0.0;
                m_cnt = 0;
            end
        end
        m_primed = 1'b1;
        m_prev   = p;
    endtask

    task automatic send_sample(input int si, input int sq, input bit dropped);
        @(posedge clk); #1;
        bus.data_in_i = WIDTH'(si);
        bus.data_in_q = WIDTH'(sq);
        bus.stb_in    = 1'b1;
        @(posedge clk); #1;
        bus.stb_in = 1'b0;
        if (dropped) m_overrun = 1'b1;
        else         model_feed(si, sq);
    endtask

    task automatic run_phasor(input int n, input int start, input int step, input int drop_at);
        int  ph;
        int  si;
        int  sq;
        real ang;
        ph = start;
        for (int k = 0; k < n; k++) begin
            ang = real'(ph) * 2.0 * PI / 65536.0;
            si  = round_r(30000.0 * $cos(ang));
            sq  = round_r(30000.0 * $sin(ang));
            send_sample(si, sq, 1'b0);
            if (k == drop_at) begin
                repeat (3) @(posedge clk);
                send_sample(-si, 12345, 1'b1);
                repeat (SPACING - 7) @(posedge clk);
            end else begin
                repeat (SPACING - 2) @(posedge clk);
            end
            ph += step;
        end
    endtask

    task automatic run_const(input int n, input int si, input int sq);
        for (int k = 0; k < n; k++) begin
            send_sample(si, sq, 1'b0);
            repeat (SPACING - 2) @(posedge clk);
        end
    endtask

    task automatic do_reset(input string name);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check({name, " rst data_out"}, bus.data_out == 0, int'(bus.data_out), 0);
        check({name, " rst stb_out"},  bus.stb_out == 1'b0, int'(bus.stb_out), 0);
        check({name, " rst overrun"},  bus.overrun == 1'b0, int'(bus.overrun), 0);
        m_primed  = 1'b0;
        m_acc     = 0.0;
        m_cnt     = 0;
        m_overrun = 1'b0;
        exp_q.delete();
        last_exp  = 0;
        last_got  = 99999;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic finish_case(input string name, input int want);
        repeat (40) @(posedge clk);
        check({name, " missing strobes"}, exp_q.size() == 0, exp_q.size(), 0);
        check({name, " data_out"},        iabs(last_got - want) <= TOL, last_got, want);
        check({name, " model pin"},       iabs(last_exp - want) <= 1, last_exp, want);
    endtask

    // Every cycle out of reset: overrun matches the model, data_out holds the last
    // expected dump (0 after reset), and each strobe consumes one expected sample.
    always @(negedge clk) begin
        if (rst_n) begin
            check("overrun", bus.overrun == m_overrun, int'(bus.overrun), int'(m_overrun));
            if (bus.stb_out) begin
                check("stb_out expected", exp_q.size() != 0, int'(bus.data_out), 0);
                if (exp_q.size() != 0) begin
                    last_exp = exp_q.pop_front();
                    last_got = int'(bus.data_out);
                end
            end
            check("data_out", iabs(int'(bus.data_out) - last_exp) <= TOL,
                  int'(bus.data_out), last_exp);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.data_in_i = '0;
        bus.data_in_q = '0;
        bus.stb_in    = 1'b0;
        m_primed = 1'b0; m_acc = 0.0; m_cnt = 0; m_overrun = 1'b0;
        last_exp = 0; last_got = 99999;
        #1;
        check("por data_out", bus.data_out == 0, int'(bus.data_out), 0);
        check("por stb_out",  bus.stb_out == 1'b0, int'(bus.stb_out), 0);
        check("por overrun",  bus.overrun == 1'b0, int'(bus.overrun), 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        run_phasor(201, 0, 1024, -1);
        finish_case("step +1024", 6400);

        do_reset("neg");
        run_phasor(101, 30000, -1024, -1);
        finish_case("step -1024", -6400);

        do_reset("satp");
        run_phasor(101, 0, 30000, -1);
        finish_case("step +30000", 32767);

        do_reset("satn");
        run_phasor(101, 0, -30000, -1);
        finish_case("step -30000", -32768);

        do_reset("static");
        run_const(101, -32768, 0);
        finish_case("static -pi", 0);

        do_reset("zero");
        run_const(101, 0, 0);
        finish_case("zero input", 0);

        do_reset("ovr");
        run_phasor(101, 0, 1024, 50);
        finish_case("overrun drop", 6400);
        check("overrun sticky", bus.overrun == 1'b1, int'(bus.overrun), 1);

        send_sample(20000, 10000, 1'b0);
        repeat (3) @(posedge clk);
        do_reset("mid-rot");
        run_phasor(101, 5000, 1024, -1);
        finish_case("after reset", 6400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
